// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions. Holds the phase encoding used by the instruction
// phase sequencer: idle (0) plus five execution phases (1..5). Encodings 6
// and 7 are unused and are treated as illegal by any FSM using phase_t.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE = 3'd0,
    PH_P1   = 3'd1,
    PH_P2   = 3'd2,
    PH_P3   = 3'd3,
    PH_P4   = 3'd4,
    PH_P5   = 3'd5
  } phase_t;

  // True only for the five legal execution phases; idle and the two illegal
  // encodings all read as "not executing".
  function automatic logic is_exec_phase(input logic [PHASE_W-1:0] ph);
    return (ph >= 3'd1) && (ph <= 3'd5);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchronizer plus level debounce for a raw, active-low button.
// The filtered level only follows the synchronized input once the two have
// disagreed for DEB_CYCLES consecutive cycles; any agreement clears the count.
//
// Parameters:
//   DEB_CYCLES  consecutive differing cycles required to accept a new level
// Ports:
//   clk         system clock
//   rst         synchronous active-low reset
//   btn_n       raw asynchronous button input (0 = pressed)
//   level       debounced level (1 = released)
//   fall_pulse  one-cycle pulse on each accepted 1->0 change of level
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic fall_pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state logic: synchronizer shift, stability counter, and the
  // registered falling-edge pulse that lines up with the level change.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // This is the DEB_CYCLES-th differing cycle: accept the new level.
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    fall_d = level_q & ~level_d;
  end

  // State registers; reset assumes the button is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Run/stop control for a five-phase instruction cycle. A debounced press of
// the exec button starts execution from idle; P1..P5 then repeat until a stop
// is requested (another press, or hlt). A stop always lets the current
// instruction reach P5 before returning to idle. instr_cnt counts completed
// instructions (one per P5).
//
// Optional feature macro: PHASE_SEQ_STEP_EN
//   When defined, the step_mode input exists and step_mode=1 makes every P5
//   return to idle (single-instruction stepping, halted stays 0). When not
//   defined, the port is absent and stepping is disabled.
//
// Parameters:
//   DEB_CYCLES  exec debounce length in cycles
//   CNT_W       width of the retired-instruction counter
// Ports:
//   clk         system clock
//   rst         synchronous active-low reset
//   exec        raw active-low run/stop button
//   hlt         halt request from the control decoder
//   step_mode   single-step enable (PHASE_SEQ_STEP_EN builds only)
//   phase       current phase, 0 = idle, 1..5 = executing
//   executing   high while phase is 1..5
//   halted      high in idle after a stop caused by hlt
//   exec_press  one-cycle pulse per accepted press
//   instr_cnt   completed instruction count (wraps)
// -----------------------------------------------------------------------------
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec,
  input  logic             hlt,
`ifdef PHASE_SEQ_STEP_EN
  input  logic             step_mode,
`endif
  output logic [2:0]       phase,
  output logic             executing,
  output logic             halted,
  output logic             exec_press,
  output logic [CNT_W-1:0] instr_cnt
);

  logic exec_level;
  logic exec_fall;
  logic press;
  logic step_en;

  phase_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic             stop_flag_q, stop_flag_d;
  logic             stop_req_q, stop_req_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             in_exec;
  logic             stop_by_hlt;

  button_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_exec_deb (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (exec),
    .level      (exec_level),
    .fall_pulse (exec_fall)
  );

  // The fall pulse and the low level are registered on the same edge, so
  // qualifying with the level only guards against a stale pulse.
  assign press = exec_fall & ~exec_level;

`ifdef PHASE_SEQ_STEP_EN
  assign step_en = step_mode;
`else
  assign step_en = 1'b0;
`endif

  // Next-state and bookkeeping. Stop requests are latched during P1..P5 and
  // only acted on at P5, so an instruction is never cut short.
  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    stop_flag_d = stop_flag_q;
    stop_req_d  = stop_req_q;
    instr_cnt_d = instr_cnt_q;
    in_exec     = is_exec_phase(state_q);
    stop_by_hlt = stop_flag_q | hlt;

    if (in_exec && press) begin
      stop_req_d = 1'b1;
    end
    if (in_exec && hlt) begin
      stop_flag_d = 1'b1;
    end

    case (state_q)
      PH_IDLE: begin
        if (press) begin
          state_d     = PH_P1;
          halted_d    = 1'b0;
          stop_flag_d = 1'b0;
          stop_req_d  = 1'b0;
        end
      end
      PH_P1: state_d = PH_P2;
      PH_P2: state_d = PH_P3;
      PH_P3: state_d = PH_P4;
      PH_P4: state_d = PH_P5;
      PH_P5: begin
        instr_cnt_d = instr_cnt_q + 1'b1;
        // A press seen here only stops; it is not also taken as a restart.
        if (stop_by_hlt || stop_req_q || press || step_en) begin
          state_d    = PH_IDLE;
          halted_d   = stop_by_hlt & ~step_en;
          stop_req_d = 1'b0;
        end else begin
          state_d = PH_P1;
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  // State registers; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= PH_IDLE;
      halted_q    <= 1'b0;
      stop_flag_q <= 1'b0;
      stop_req_q  <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      stop_flag_q <= stop_flag_d;
      stop_req_q  <= stop_req_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign phase      = state_q;
  assign executing  = is_exec_phase(state_q);
  assign halted     = halted_q;
  assign exec_press = exec_fall;
  assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
// Directed bench for phase_sequencer with DEB_CYCLES=4. A vector table covers
// reset, debounce rejection/acceptance, the phase loop and a hlt stop;
// hand-written sequences cover stop-by-press, restart, press+hlt in P5,
// counter wrap and reset mid-instruction (plus stepping when
// PHASE_SEQ_STEP_EN is defined).
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

  logic        clk;
  logic        rst;
  logic        exec;
  logic        hlt;
`ifdef PHASE_SEQ_STEP_EN
  logic        step_mode;
`endif
  logic [2:0]  phase;
  logic        executing;
  logic        halted;
  logic        exec_press;
  logic [15:0] instr_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst_n;
    logic        exec_n;
    logic        hlt;
    logic [2:0]  ph;
    logic        exe;
    logic        hal;
    logic        prs;
    logic [15:0] cnt;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  phase_sequencer #(
    .DEB_CYCLES (4),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .exec       (exec),
    .hlt        (hlt),
`ifdef PHASE_SEQ_STEP_EN
    .step_mode  (step_mode),
`endif
    .phase      (phase),
    .executing  (executing),
    .halted     (halted),
    .exec_press (exec_press),
    .instr_cnt  (instr_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a falling edge, well away from the rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic h);
    rst  = r;
    exec = e;
    hlt  = h;
  endtask

  // One rising edge, then settle to the falling edge where outputs are read.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic holdTicks(input int n, input logic e, input logic h);
    applyStimulus(1'b1, e, h);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] ph, input logic exe,
                             input logic hal, input logic prs, input logic [15:0] cnt);
    checkField({tag, ".phase"}, 16'(phase), 16'(ph));
    checkField({tag, ".executing"}, 16'(executing), 16'(exe));
    checkField({tag, ".halted"}, 16'(halted), 16'(hal));
    checkField({tag, ".exec_press"}, 16'(exec_press), 16'(prs));
    checkField({tag, ".instr_cnt"}, instr_cnt, cnt);
  endtask

  // Hold exec low for six cycles; the accepted press shows on the sixth.
  task automatic pressButton(input string tag, input logic [2:0] ph, input logic hal,
                             input logic [15:0] cnt);
    holdTicks(5, 1'b0, 1'b0);
    checkField({tag, ".no_early_press"}, 16'(exec_press), 16'd0);
    holdTicks(1, 1'b0, 1'b0);
    checkOutput(tag, ph, is_exec(ph), hal, 1'b1, cnt);
  endtask

  function automatic logic is_exec(input logic [2:0] ph);
    return (ph != 3'd0);
  endfunction

  task automatic mk(input int i, input logic r, input logic e, input logic h, input logic [2:0] ph,
                    input logic exe, input logic hal, input logic prs, input logic [15:0] cnt);
    vecs[i] = '{r, e, h, ph, exe, hal, prs, cnt};
  endtask

  initial begin
    int exe_cycles;

    // Run and halt trace: 3-cycle glitch rejected, 6-cycle press accepted,
    // two instructions, hlt in P3 of the second one.
    mk(0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 3; i++)  mk(i, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 4; i <= 8; i++)  mk(i, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 9; i <= 13; i++) mk(i, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    mk(14, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'd0);
    for (int i = 15; i <= 19; i++) mk(i, 1'b1, 1'b1, 1'b0, 3'(i - 14), 1'b1, 1'b0, 1'b0, 16'd0);
    mk(20, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 16'd1);
    mk(21, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 16'd1);
    mk(22, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 16'd1);
    mk(23, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 16'd1);
    mk(24, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 16'd1);
    mk(25, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd2);
    mk(26, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd2);

`ifdef PHASE_SEQ_STEP_EN
    step_mode = 1'b0;
`endif
    applyStimulus(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].exec_n, vecs[i].hlt);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].ph, vecs[i].exe, vecs[i].hal,
                  vecs[i].prs, vecs[i].cnt);
    end

    // Stop by press: start, then a second press lands while in P2.
    pressButton("stop_start", 3'd0, 1'b1, 16'd2);
    holdTicks(1, 1'b1, 1'b0);
    checkOutput("stop_p1", 3'd1, 1'b1, 1'b0, 1'b0, 16'd2);
    holdTicks(5, 1'b1, 1'b0);
    checkOutput("stop_loop", 3'd1, 1'b1, 1'b0, 1'b0, 16'd3);
    pressButton("stop_press_p2", 3'd2, 1'b0, 16'd4);
    holdTicks(1, 1'b1, 1'b0);
    checkOutput("stop_p3", 3'd3, 1'b1, 1'b0, 1'b0, 16'd4);
    holdTicks(3, 1'b1, 1'b0);
    checkOutput("stop_idle", 3'd0, 1'b0, 1'b0, 1'b0, 16'd5);
    holdTicks(1, 1'b1, 1'b0);
    checkOutput("stop_stays", 3'd0, 1'b0, 1'b0, 1'b0, 16'd5);

    // Restart after a press-stop.
    holdTicks(4, 1'b1, 1'b0);
    pressButton("restart", 3'd0, 1'b0, 16'd5);
    holdTicks(1, 1'b1, 1'b0);
    checkOutput("restart_p1", 3'd1, 1'b1, 1'b0, 1'b0, 16'd5);

    // Press and hlt together in P5: stop with halted, no restart.
    holdTicks(8, 1'b1, 1'b0);
    pressButton("pr_hlt_p5", 3'd5, 1'b0, 16'd7);
    holdTicks(1, 1'b1, 1'b1);
    checkOutput("pr_hlt_idle", 3'd0, 1'b0, 1'b1, 1'b0, 16'd8);
    holdTicks(2, 1'b1, 1'b0);
    checkOutput("pr_hlt_norestart", 3'd0, 1'b0, 1'b1, 1'b0, 16'd8);

    // Counter wrap from all-ones.
    holdTicks(6, 1'b1, 1'b0);
    force dut.instr_cnt_q = 16'hFFFF;
    tick();
    release dut.instr_cnt_q;
    tick();
    checkField("wrap_preload", instr_cnt, 16'hFFFF);
    pressButton("wrap_start", 3'd0, 1'b1, 16'hFFFF);
    holdTicks(1, 1'b1, 1'b0);
    holdTicks(1, 1'b1, 1'b1);
    checkOutput("wrap_p2", 3'd2, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    holdTicks(3, 1'b1, 1'b0);
    checkOutput("wrap_p5", 3'd5, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    holdTicks(1, 1'b1, 1'b0);
    checkOutput("wrap_done", 3'd0, 1'b0, 1'b1, 1'b0, 16'd0);

    // Reset during P4 abandons the instruction.
    holdTicks(4, 1'b1, 1'b0);
    pressButton("rst_start", 3'd0, 1'b1, 16'd0);
    holdTicks(4, 1'b1, 1'b0);
    checkOutput("rst_p4", 3'd4, 1'b1, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rst_mid", 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    holdTicks(2, 1'b1, 1'b0);
    checkOutput("rst_after", 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);

`ifdef PHASE_SEQ_STEP_EN
    // Single-step: each press runs exactly one instruction.
    step_mode = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      holdTicks(4, 1'b1, 1'b0);
      pressButton($sformatf("step%0d_press", n), 3'd0, 1'b0, 16'(n - 1));
      exe_cycles = 0;
      for (int k = 0; k < 7; k++) begin
        holdTicks(1, 1'b1, 1'b0);
        if (executing === 1'b1) exe_cycles++;
      end
      checkField($sformatf("step%0d_exe_cycles", n), 16'(exe_cycles), 16'd5);
      checkOutput($sformatf("step%0d_done", n), 3'd0, 1'b0, 1'b0, 1'b0, 16'(n));
    end
    step_mode = 1'b0;
`else
    exe_cycles = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DEB_CYCLES, default 16, SHALL set how many consecutive cycles the synchronized exec level must hold before it is accepted.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the retired-instruction counter.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 exec  input  1  raw, asynchronous, active-low run/stop push-button.
REQ-007 hlt  input  1  halt request from the control decoder; valid in any phase.
REQ-008 step_mode  input  1  1 = execute one instruction per press (present only with PHASE_SEQ_STEP_EN).
REQ-009 phase  output  3  current phase: 0 = idle, 1..5 = execution phases.
REQ-010 executing  output  1  high while phase is 1..5.
REQ-011 halted  output  1  high in idle after a stop caused by hlt.
REQ-012 exec_press  output  1  one-cycle pulse on each accepted press.
REQ-013 instr_cnt  output  CNT_W  count of completed instructions.

Function
REQ-014 exec SHALL pass through a 2-flop synchronizer; the first flop's reset value is 1 (button released).
REQ-015 The filtered level SHALL change only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles.
REQ-016 The stability counter SHALL clear whenever the synchronized level equals the filtered level.
REQ-017 exec_press SHALL pulse for exactly one cycle on each 1->0 transition of the filtered level.
REQ-018 The FSM SHALL have states IDLE(0), P1, P2, P3, P4 and P5, with phase equal to the state number.
REQ-019 IDLE: on exec_press, the FSM SHALL go to P1, clear halted and clear stop_flag; otherwise it stays in IDLE.
REQ-020 P1 through P4 SHALL each advance unconditionally to the next phase after one cycle.
REQ-021 Any exec_press while executing SHALL set stop_req.
REQ-022 hlt high in any of P1..P5 SHALL set stop_flag.
REQ-023 In P5, instr_cnt SHALL increment, wrapping from all-ones to 0.
REQ-024 P5 -> IDLE SHALL occur if stop_flag, stop_req, a same-cycle hlt, or a same-cycle exec_press is true; otherwise P5 -> P1.
REQ-025 On P5 -> IDLE, halted SHALL be set if and only if the stop was caused by hlt (stop_flag or same-cycle hlt), and stop_req SHALL clear.
REQ-026 An exec_press in the same cycle as the P5 -> IDLE transition SHALL NOT restart execution.
REQ-027 An instruction always completes: no path from P1..P4 to IDLE exists except reset.
REQ-028 phase SHALL never take the values 6 or 7; if it does, the FSM SHALL go to IDLE on the next cycle.

Reset
REQ-029 With rst=0 at a clock edge, reset SHALL win over all other inputs.
REQ-030 On reset: phase=0, executing=0, halted=0, exec_press=0, instr_cnt=0, stop_flag=0, stop_req=0.
REQ-031 On reset: debounce counter=0, synchronizer flops=1, filtered level=1.
REQ-032 A reset asserted mid-instruction (in any of P1..P5) SHALL abandon the instruction without incrementing instr_cnt.

Configuration
REQ-033 With PHASE_SEQ_STEP_EN defined, the step_mode port SHALL exist, and step_mode=1 at P5 SHALL force P5 -> IDLE with halted=0.
REQ-034 Without PHASE_SEQ_STEP_EN, the step_mode port SHALL be absent and the block SHALL behave as if step_mode=0.

Structure
REQ-035 The phase encodings (PH_IDLE..PH_P5) SHALL live in the shared package cpu_pkg as a 3-bit typedef with constants.
REQ-036 The synchronizer and debounce logic SHALL be a sub-module named button_debounce, with parameter DEB_CYCLES and outputs level and fall_pulse.

Verification (DEB_CYCLES=4 in the bench)
REQ-037 Run: exec low for 3 cycles then high -> no exec_press and phase stays 0; exec low for 6 cycles -> one exec_press, then phase sequence 1,2,3,4,5,1,...
REQ-038 Halt: hlt pulsed in P3 of the 2nd instruction -> P5 -> 0, halted=1, instr_cnt=2.
REQ-039 Stop: a press accepted in P2 -> current instruction finishes, phase returns to 0, halted=0; a next press restarts at P1 with halted=0.
REQ-040 Boundaries: instr_cnt forced to 16'hFFFF -> next P5 gives 0. Press and hlt in the same P5 -> IDLE with halted=1 and no restart.
REQ-041 Reset: rst=0 during P4 -> next cycle phase=0, executing=0, instr_cnt unchanged from its pre-reset value or 0 per REQ-030, no increment.
REQ-042 Step (with PHASE_SEQ_STEP_EN, step_mode=1): each press -> exactly 5 executing cycles, instr_cnt +1, halted=0.
